// File: rtl/cnn_sched_pkg.sv
// rtl/cnn_sched_pkg.sv - shared state encoding and geometry helpers for the window scheduler
package cnn_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_e;

  // Largest window origin that still keeps the whole kernel inside the map.
  function automatic int last_origin(input int map_dim, input int kernel, input int stride);
    return ((map_dim - kernel) / stride) * stride;
  endfunction

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/window_origin_counter.sv
// rtl/window_origin_counter.sv - raster-order window origin counter with stride and column wrap
module window_origin_counter
  import cnn_sched_pkg::*;
#(
  parameter int MAP_ROWS   = 25,
  parameter int MAP_COLS   = 30,
  parameter int KERNEL     = 5,
  parameter int STRIDE     = 1,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] row,
  output logic [ADDR_WIDTH-1:0] col,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(last_origin(MAP_ROWS, KERNEL, STRIDE));
  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(last_origin(MAP_COLS, KERNEL, STRIDE));
  localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(STRIDE);

  logic [ADDR_WIDTH-1:0] row_q, row_d;
  logic [ADDR_WIDTH-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (load) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (col_q + STEP <= LAST_COL) begin
        col_d = col_q + STEP;
      end else begin
        col_d = '0;
        row_d = row_q + STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = (row_q == LAST_ROW) && (col_q == LAST_COL);

endmodule

// File: rtl/conv_window_scheduler.sv
// rtl/conv_window_scheduler.sv - scan FSM and tap expansion of a KERNELxKERNEL window over the map
module conv_window_scheduler
  import cnn_sched_pkg::*;
#(
  parameter int  MAP_ROWS   = 25,
  parameter int  MAP_COLS   = 30,
  parameter int  KERNEL     = 5,
  parameter int  STRIDE     = 1,
  parameter int  ADDR_WIDTH = 32,
  localparam int PORT_NUM   = KERNEL * KERNEL
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  input  logic                           win_ready,
  output logic                           win_valid,
  output logic                           win_last,
  output logic [PORT_NUM*ADDR_WIDTH-1:0] x_bus,
  output logic [PORT_NUM*ADDR_WIDTH-1:0] y_bus,
  output logic [ADDR_WIDTH-1:0]          out_row,
  output logic [ADDR_WIDTH-1:0]          out_col,
  output logic                           busy,
  output logic                           done
);

  if (KERNEL > MAP_ROWS || KERNEL > MAP_COLS || STRIDE < 1) begin : g_bad_geometry
    $error("conv_window_scheduler: kernel larger than map or zero stride");
  end
  if (ADDR_WIDTH < 62 &&
      longint'(MAP_ROWS + KERNEL) >= (longint'(1) << ADDR_WIDTH)) begin : g_bad_width
    $error("conv_window_scheduler: coordinates do not fit ADDR_WIDTH");
  end

  sched_state_e state_q, state_d;
  logic         load, advance, last;
  logic [ADDR_WIDTH-1:0] row, col;

  window_origin_counter #(
    .MAP_ROWS   (MAP_ROWS),
    .MAP_COLS   (MAP_COLS),
    .KERNEL     (KERNEL),
    .STRIDE     (STRIDE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_origin (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .advance (advance),
    .row     (row),
    .col     (col),
    .last    (last)
  );

  // abort outranks a same-cycle handshake, so the counter never advances on it.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (win_ready) begin
          if (last) state_d = DONE;
          else      advance = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign win_valid = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign win_last  = (state_q == RUN) && last;
  assign out_row   = row;
  assign out_col   = col;

  for (genvar kr = 0; kr < KERNEL; kr++) begin : g_tap_row
    for (genvar kc = 0; kc < KERNEL; kc++) begin : g_tap_col
      localparam int LSB = lane_lsb(kr * KERNEL + kc, ADDR_WIDTH);
      assign x_bus[LSB +: ADDR_WIDTH] = row + ADDR_WIDTH'(kr);
      assign y_bus[LSB +: ADDR_WIDTH] = col + ADDR_WIDTH'(kc);
    end
  end

endmodule

// File: tb/tb_conv_window_scheduler.sv
// tb/tb_conv_window_scheduler.sv - directed self-checking bench for conv_window_scheduler
module tb_conv_window_scheduler;

  localparam int AW = 32;
  localparam int PN = 25;

  logic clk = 1'b0;
  logic rst, start, abort, win_ready;
  logic win_valid, win_last, busy, done;
  logic [PN*AW-1:0] x_bus, y_bus;
  logic [AW-1:0] out_row, out_col;

  logic start1, abort1, ready1;
  logic win_valid1, win_last1, busy1, done1;
  logic [PN*AW-1:0] x_bus1, y_bus1;
  logic [AW-1:0] out_row1, out_col1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conv_window_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .win_ready(win_ready),
    .win_valid(win_valid), .win_last(win_last), .x_bus(x_bus), .y_bus(y_bus),
    .out_row(out_row), .out_col(out_col), .busy(busy), .done(done)
  );

  conv_window_scheduler #(.STRIDE(2)) dut_s2 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .win_ready(ready1),
    .win_valid(win_valid1), .win_last(win_last1), .x_bus(x_bus1), .y_bus(y_bus1),
    .out_row(out_row1), .out_col(out_col1), .busy(busy1), .done(done1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [PN*AW-1:0] model_bus(input int base);
    logic [PN*AW-1:0] b;
    b = '0;
    for (int kr = 0; kr < 5; kr++)
      for (int kc = 0; kc < 5; kc++)
        b[(kr*5+kc)*AW +: AW] = AW'(base + kr);
    return b;
  endfunction

  // y lanes depend on kc rather than kr, so build them separately.
  function automatic logic [PN*AW-1:0] model_ybus(input int base);
    logic [PN*AW-1:0] b;
    b = '0;
    for (int kr = 0; kr < 5; kr++)
      for (int kc = 0; kc < 5; kc++)
        b[(kr*5+kc)*AW +: AW] = AW'(base + kc);
    return b;
  endfunction

  function automatic logic [AW-1:0] lane(input logic [PN*AW-1:0] b, input int k);
    return b[k*AW +: AW];
  endfunction

  task automatic check_reset_outputs();
    check("rst_valid", win_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_last", win_last, 0);
    check("rst_origin", {out_row, out_col}, 64'd0);
    check("rst_xbus", x_bus == model_bus(0), 1);
    check("rst_ybus", y_bus == model_ybus(0), 1);
  endtask

  task automatic do_start(input logic with_abort);
    start = 1'b1;
    abort = with_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Scoreboard walk of one scan on the default instance, starting in its first RUN cycle.
  task automatic scan0(input bit rnd, input int abort_at, input bit poke, output int nwin, output int ncyc);
    int er, ec;
    bit fin;
    er = 0; ec = 0; nwin = 0; ncyc = 0; fin = 0;
    while (!fin) begin
      if (ncyc > 4000) begin
        check("scan_timeout", ncyc, 0);
        fin = 1;
      end else if (!win_valid) begin
        check("valid_in_scan", win_valid, 1);
        fin = 1;
      end else begin
        check("origin", {out_row, out_col}, {er, ec});
        check("x_bus", x_bus == model_bus(er), 1);
        check("y_bus", y_bus == model_ybus(ec), 1);
        check("win_last", win_last, (er == 20 && ec == 25));
        check("busy", busy, 1);
        if (abort_at >= 0 && nwin == abort_at) begin
          win_ready = 1'b0;
          @(negedge clk);
          check("stall_hold", {out_row, out_col}, {er, ec});
          abort = 1'b1;
          win_ready = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          check("abort_valid", win_valid, 0);
          check("abort_busy", busy, 0);
          check("abort_done", done, 0);
          @(negedge clk);
          check("abort_no_done", done, 0);
          fin = 1;
        end else begin
          win_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
          if (win_ready) begin
            nwin++;
            if (er == 20 && ec == 25) begin
              check("last_x24", lane(x_bus, 24), 24);
              check("last_y24", lane(y_bus, 24), 29);
              @(negedge clk);
              ncyc++;
              check("done_pulse", done, 1);
              check("done_busy", busy, 0);
              check("done_valid", win_valid, 0);
              start = poke;
              @(negedge clk);
              start = 1'b0;
              check("done_clear", done, 0);
              check("done_start_ignored", win_valid, 0);
              fin = 1;
            end else if (ec + 1 <= 25) begin
              ec++;
            end else begin
              ec = 0;
              er++;
            end
          end
          if (!fin) begin
            start = poke && (nwin == 50);
            @(negedge clk);
            start = 1'b0;
            ncyc++;
          end
        end
      end
    end
    win_ready = 1'b1;
  endtask

  initial begin
    int n, c, lasts, after_r, after_c, last_r, last_c, last_x, last_y;
    bit prev_wrap, got_done;
    rst = 1'b1; start = 1'b0; abort = 1'b0; win_ready = 1'b1;
    start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    check("idle_valid", win_valid, 0);

    do_start(1'b0);
    check("first_x0", lane(x_bus, 0), 0);
    check("first_x24", lane(x_bus, 24), 4);
    check("first_y24", lane(y_bus, 24), 4);
    scan0(0, -1, 0, n, c);
    check("full_count", n, 546);
    check("full_cycles", c, 546);

    do_start(1'b0);
    scan0(1, -1, 1, n, c);
    check("rand_count", n, 546);

    do_start(1'b0);
    scan0(0, 100, 0, n, c);
    check("abort_count", n, 100);
    do_start(1'b0);
    scan0(0, -1, 0, n, c);
    check("restart_count", n, 546);

    do_start(1'b1);
    scan0(0, -1, 0, n, c);
    check("start_abort_count", n, 546);

    do_start(1'b0);
    repeat (10) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0; lasts = 0; after_r = -1; after_c = -1; last_r = -1; last_c = -1;
    last_x = -1; last_y = -1; prev_wrap = 0; got_done = 0;
    for (int cy = 0; cy < 400 && !got_done; cy++) begin
      if (done1) begin
        got_done = 1;
      end else if (win_valid1) begin
        n++;
        if (prev_wrap) begin
          after_r = int'(out_row1);
          after_c = int'(out_col1);
        end
        prev_wrap = (out_row1 == 0 && out_col1 == 24);
        if (win_last1) begin
          lasts++;
          last_r = int'(out_row1);
          last_c = int'(out_col1);
          last_x = int'(lane(x_bus1, 24));
          last_y = int'(lane(y_bus1, 24));
        end
        @(negedge clk);
      end else begin
        @(negedge clk);
      end
    end
    check("s2_done_seen", got_done, 1);
    check("s2_count", n, 143);
    check("s2_wrap", {after_r, after_c}, {32'd2, 32'd0});
    check("s2_last_count", lasts, 1);
    check("s2_last_origin", {last_r, last_c}, {32'd20, 32'd24});
    check("s2_last_x24", last_x, 24);
    check("s2_last_y24", last_y, 28);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_window_scheduler.md
# conv_window_scheduler

Sequencer for the CNN constant address map. On a start pulse it walks a KERNEL×KERNEL convolution window over a MAP_ROWS×MAP_COLS feature map in raster order with a fixed stride. For each window position it drives one (x, y) coordinate pair per window tap onto the packed x/y buses of the address map. Windows are handed downstream through a valid/ready handshake.

## Interface
Parameters:
- MAP_ROWS, 25: feature-map rows; x range 0..MAP_ROWS-1.
- MAP_COLS, 30: feature-map columns; y range 0..MAP_COLS-1.
- KERNEL, 5: window side; PORT_NUM = KERNEL*KERNEL, derived, not overridable.
- STRIDE, 1: step between window origins in both axes; ≥1.
- ADDR_WIDTH, 32: width of each packed coordinate lane.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a full map scan.
- abort  in  1  synchronous abort of a scan in progress.
- win_ready  in  1  downstream accepts current window.
- win_valid  out  1  x_bus/y_bus hold a valid window.
- win_last  out  1  current window is the final one of the scan.
- x_bus  out  PORT_NUM*ADDR_WIDTH  tap row coordinates; lane k = bits [(k+1)*ADDR_WIDTH-1 : k*ADDR_WIDTH].
- y_bus  out  PORT_NUM*ADDR_WIDTH  tap column coordinates; same lane packing.
- out_row  out  ADDR_WIDTH  current window origin row.
- out_col  out  ADDR_WIDTH  current window origin column.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the last window is accepted.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on start. Origin (row, col) loads (0, 0).
- RUN, win_valid&win_ready, not last: advance the origin.
  - If col+STRIDE ≤ LAST_COL: col += STRIDE.
  - Otherwise col = 0, row += STRIDE.
- RUN, win_valid&win_ready&win_last → DONE.
- DONE → IDLE unconditionally after one cycle. done=1 only in DONE.
- abort in RUN → IDLE next cycle, no done pulse. abort has priority over a same-cycle handshake.
- start outside IDLE is ignored. start and abort together in IDLE: start wins.
- LAST_ROW = largest multiple of STRIDE ≤ MAP_ROWS-KERNEL. LAST_COL is the same with MAP_COLS.
- win_last = (row==LAST_ROW && col==LAST_COL) while in RUN.
- Tap k = kr*KERNEL + kc (kr, kc in 0..KERNEL-1): x lane k = row+kr, y lane k = col+kc.
  - Each lane is zero-extended to ADDR_WIDTH.
  - No coordinate ever exceeds MAP_ROWS-1 or MAP_COLS-1.
- Window count per scan = (LAST_ROW/STRIDE+1)*(LAST_COL/STRIDE+1).
- Elaboration-time error if KERNEL > MAP_ROWS, KERNEL > MAP_COLS, STRIDE = 0, or MAP_ROWS+KERNEL does not fit in ADDR_WIDTH.

## Timing
- Reset values: state IDLE; win_valid, win_last, busy, done = 0; out_row, out_col = 0; x_bus, y_bus = lane pattern of origin (0, 0).
- start sampled at edge t: win_valid=1 and busy=1 from cycle t+1, origin (0, 0).
- Throughput: one window per cycle while win_ready is held high.
- Backpressure: while win_valid && !win_ready, all outputs hold stable.
- Done latency: last window accepted at edge t → done=1 and busy=0 in cycle t+1 → IDLE at t+2. A new start is accepted from cycle t+2.
- x_bus and y_bus are pure functions of the registered origin through constant adders. Add no extra pipeline stage.
- rst mid-scan: all outputs return to reset values on the next edge. No done pulse.

## Structure
- Shared package cnn_sched_pkg holds:
  - state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - LAST_ROW/LAST_COL computation as a constant function;
  - the lane-packing helper (lane index → bit slice).
- One sub-module, window_origin_counter: row/col registers, stride advance, col wrap, last detection. Its inputs are load, advance, clk, rst.
- The FSM and the tap-expansion generate loop stay in the top.

## Test plan
- Default parameters, win_ready tied 1, start pulse: exactly 546 windows (21×26) on consecutive cycles, then done one cycle after the last window. First window: x lane 0=0, lane 24=4; y lane 0=0, lane 24=4. Last window: origin (20, 25), x lane 24=24, y lane 24=29.
- STRIDE=2: 143 windows (11×13). Origins wrap from (0, 24) to (2, 0). Last origin (20, 24), with win_last=1 on it only.
- Random win_ready pattern, default parameters: buses stable during stalls, no window skipped or duplicated. The scoreboard matches the raster order.
- abort at window 100 while stalled: IDLE next cycle, win_valid=0, no done pulse. A subsequent start restarts at origin (0, 0).
- start pulsed during RUN and in DONE: ignored, scan count unchanged. Reset asserted mid-scan: all outputs at reset values after one edge.
- start and abort in the same IDLE cycle: scan starts normally.
